// File: rtl/op_seq_pkg.sv
// rtl/op_seq_pkg.sv - shared types and instruction-field constants for the op_sequencer program sequencer
// OP_SEQ_STEP_EN adds the WAIT_STEP state used by single-step mode.
package op_seq_pkg;

  localparam int INSTR_W     = 12;
  localparam int OPC_MSB     = 11;
  localparam int OPC_LSB     = 8;
  localparam int ALU_OP_MSB  = 10;
  localparam int OPERAND_MSB = 7;
  localparam int OPERAND_LSB = 0;
  localparam int OPC_ALU_BIT = 3;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_JMP  = 4'h1;
  localparam logic [3:0] OPC_JZ   = 4'h2;
  localparam logic [3:0] OPC_HALT = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LOAD      = 3'd2,
    ST_EXEC      = 3'd3,
`ifdef OP_SEQ_STEP_EN
    ST_WAIT_STEP = 3'd5,
`endif
    ST_HALTED    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/op_seq_decoder.sv
// rtl/op_seq_decoder.sv - combinational instruction-register decode for op_sequencer
// Reserved opcodes 4'h4-4'h7 raise no flag, so they fall through as NOP.
module op_seq_decoder
  import op_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic               is_alu,
  output logic               is_jmp,
  output logic               is_jz,
  output logic               is_halt,
  output logic [2:0]         alu_op,
  output logic [7:0]         operand
);

  logic [3:0] opcode;

  assign opcode  = ir[OPC_MSB:OPC_LSB];
  assign is_alu  = opcode[OPC_ALU_BIT];
  assign is_jmp  = (opcode == OPC_JMP);
  assign is_jz   = (opcode == OPC_JZ);
  assign is_halt = (opcode == OPC_HALT);
  assign alu_op  = ir[ALU_OP_MSB:OPC_LSB];
  assign operand = ir[OPERAND_MSB:OPERAND_LSB];

endmodule

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - fetch/load/exec program sequencer driving the accumulator datapath
// Define OP_SEQ_STEP_EN to add the step port and pause after every executed instruction.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef OP_SEQ_STEP_EN
  input  logic               step,
`endif
  output logic [PC_W-1:0]    pm_addr,
  output logic               pm_rd_en,
  input  logic [INSTR_W-1:0] pm_data,
  input  logic [7:0]         acc_value,
  output logic [2:0]         operation_code,
  output logic [7:0]         in_b,
  output logic               aku_enable,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted
);

  seq_state_e         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic               rd_en_q, rd_en_d;

  logic       is_alu, is_jmp, is_jz, is_halt;
  logic [2:0] alu_op;
  logic [7:0] operand;
  logic       take_jump;

  op_seq_decoder u_decoder (
    .ir      (ir_q),
    .is_alu  (is_alu),
    .is_jmp  (is_jmp),
    .is_jz   (is_jz),
    .is_halt (is_halt),
    .alu_op  (alu_op),
    .operand (operand)
  );

  // acc_value already includes the previous ALU result, loaded at the end of its EXEC.
  assign take_jump = is_jmp || (is_jz && (acc_value == 8'h00));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        ir_d    = pm_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_halt) begin
          state_d = ST_HALTED;
        end else begin
`ifdef OP_SEQ_STEP_EN
          state_d = ST_WAIT_STEP;
`else
          state_d = ST_FETCH;
`endif
          pc_d = take_jump ? operand[PC_W-1:0] : pc_q + PC_W'(1);
        end
      end
`ifdef OP_SEQ_STEP_EN
      ST_WAIT_STEP: if (step) state_d = ST_FETCH;
`endif
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
    rd_en_d  = (state_d == ST_FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      rd_en_q  <= rd_en_d;
    end
  end

  assign pm_addr        = pc_q;
  assign pm_rd_en       = rd_en_q;
  assign pc             = pc_q;
  assign operation_code = alu_op;
  assign in_b           = operand;
  assign aku_enable     = (state_q == ST_EXEC) && is_alu;
  assign busy           = busy_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - directed self-checking bench for op_sequencer (PC_W=8 and PC_W=4 instances)
module tb_op_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [7:0]  pm_addr_a, in_b_a, pc_a, acc_a = 8'h00;
  logic        pm_rd_en_a, aku_a, busy_a, halted_a;
  logic [11:0] pm_data_a = 12'h000;
  logic [2:0]  opc_a;
  logic [11:0] mem_a [256];

  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [3:0]  pm_addr_b, pc_b;
  logic [7:0]  in_b_b;
  logic        pm_rd_en_b, aku_b, busy_b, halted_b;
  logic [11:0] pm_data_b = 12'h000;
  logic [2:0]  opc_b;
  logic [11:0] mem_b [16];
`ifdef OP_SEQ_STEP_EN
  logic        step_a = 1'b1, step_b = 1'b1;
`endif

  int total = 0;
  int bad   = 0;

  op_sequencer #(.PC_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a),
`ifdef OP_SEQ_STEP_EN
    .step(step_a),
`endif
    .pm_addr(pm_addr_a), .pm_rd_en(pm_rd_en_a), .pm_data(pm_data_a),
    .acc_value(acc_a), .operation_code(opc_a), .in_b(in_b_a),
    .aku_enable(aku_a), .pc(pc_a), .busy(busy_a), .halted(halted_a)
  );

  op_sequencer #(.PC_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b),
`ifdef OP_SEQ_STEP_EN
    .step(step_b),
`endif
    .pm_addr(pm_addr_b), .pm_rd_en(pm_rd_en_b), .pm_data(pm_data_b),
    .acc_value(8'h00), .operation_code(opc_b), .in_b(in_b_b),
    .aku_enable(aku_b), .pc(pc_b), .busy(busy_b), .halted(halted_b)
  );

  always @(posedge clk) begin
    if (pm_rd_en_a) pm_data_a <= mem_a[pm_addr_a];
    if (pm_rd_en_b) pm_data_b <= mem_b[pm_addr_b];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    tick();
    rst_a = 1'b0;
  endtask

  task automatic start_pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic clear_mem_a();
    for (int i = 0; i < 256; i++) mem_a[i] = 12'h300;
  endtask

  initial begin
    int viol;
    clear_mem_a();
    for (int i = 0; i < 16; i++) mem_b[i] = 12'h300;

    // reset values
    reset_a();
    chk("rst_pm_addr", pm_addr_a, 8'h00);
    chk("rst_rd_en", pm_rd_en_a, 1'b0);
    chk("rst_opc", opc_a, 3'd0);
    chk("rst_in_b", in_b_a, 8'h00);
    chk("rst_aku", aku_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_halted", halted_a, 1'b0);
    chk("rst_pc", pc_a, 8'h00);

    // ALU op 6, B=0x0A
    mem_a[0] = 12'hE0A;
    mem_a[1] = 12'h000;
    start_pulse_a();
    chk("alu_fetch_rd", pm_rd_en_a, 1'b1);
    chk("alu_fetch_addr", pm_addr_a, 8'h00);
    chk("alu_fetch_busy", busy_a, 1'b1);
    tick();
    chk("alu_load_aku", aku_a, 1'b0);
    chk("alu_load_rd", pm_rd_en_a, 1'b0);
    tick();
    chk("alu_exec_aku", aku_a, 1'b1);
    chk("alu_exec_opc", opc_a, 3'd6);
    chk("alu_exec_in_b", in_b_a, 8'h0A);
    tick();
    chk("alu_next_aku", aku_a, 1'b0);
    chk("alu_next_rd", pm_rd_en_a, 1'b1);
    chk("alu_next_addr", pm_addr_a, 8'h01);
    chk("alu_hold_opc", opc_a, 3'd6);
    chk("alu_hold_in_b", in_b_a, 8'h0A);

    // JMP 5
    reset_a();
    mem_a[0] = 12'h105;
    start_pulse_a();
    tick();
    tick();
    chk("jmp_exec_aku", aku_a, 1'b0);
    tick();
    chk("jmp_next_rd", pm_rd_en_a, 1'b1);
    chk("jmp_next_addr", pm_addr_a, 8'h05);

    // JZ 0x20, accumulator zero
    reset_a();
    mem_a[0] = 12'h220;
    acc_a = 8'h00;
    start_pulse_a();
    tick();
    tick();
    tick();
    chk("jz_taken_addr", pm_addr_a, 8'h20);
    chk("jz_taken_pc", pc_a, 8'h20);

    // JZ 0x20, accumulator nonzero
    reset_a();
    acc_a = 8'h01;
    start_pulse_a();
    tick();
    tick();
    tick();
    chk("jz_not_taken_addr", pm_addr_a, 8'h01);
    acc_a = 8'h00;

    // reserved opcode behaves as NOP
    reset_a();
    mem_a[0] = 12'h5FF;
    start_pulse_a();
    tick();
    tick();
    chk("rsv_exec_aku", aku_a, 1'b0);
    tick();
    chk("rsv_next_addr", pm_addr_a, 8'h01);

    // HALT at address 3
    reset_a();
    clear_mem_a();
    mem_a[0] = 12'h000;
    mem_a[1] = 12'h000;
    mem_a[2] = 12'h000;
    mem_a[3] = 12'h300;
    start_pulse_a();
    for (int i = 0; i < 12; i++) tick();
    chk("halt_halted", halted_a, 1'b1);
    chk("halt_busy", busy_a, 1'b0);
    chk("halt_pc", pc_a, 8'h03);
    viol = 0;
    start_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pm_rd_en_a !== 1'b0 || halted_a !== 1'b1 || pc_a !== 8'h03) viol++;
    end
    start_a = 1'b0;
    chk("halt_hold_20", viol, 0);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("halt_rst_halted", halted_a, 1'b0);
    chk("halt_rst_pc", pc_a, 8'h00);
    chk("halt_rst_busy", busy_a, 1'b0);

    // reset during EXEC of an ALU instruction
    mem_a[0] = 12'hE0A;
    start_pulse_a();
    tick();
    tick();
    chk("mid_exec_aku", aku_a, 1'b1);
    rst_a = 1'b1;
    tick();
    chk("mid_rst_aku", aku_a, 1'b0);
    chk("mid_rst_opc", opc_a, 3'd0);
    chk("mid_rst_in_b", in_b_a, 8'h00);
    chk("mid_rst_pc", pc_a, 8'h00);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_rd", pm_rd_en_a, 1'b0);
    rst_a = 1'b0;

    // PC_W=4: truncated jump, then wrap from 15 to 0
    mem_b[0]  = 12'h1F3;
    mem_b[3]  = 12'h10F;
    mem_b[15] = 12'h000;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    tick();
    chk("w4_trunc_addr", pm_addr_b, 4'h3);
    tick();
    tick();
    tick();
    chk("w4_jmp15_addr", pm_addr_b, 4'hF);
    tick();
    tick();
    tick();
    chk("w4_wrap_addr", pm_addr_b, 4'h0);
    chk("w4_wrap_rd", pm_rd_en_b, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
